// File: rtl/spi2dac_pkg.sv
// Shared definitions for the multi-channel SPI DAC driver: FSM state encoding,
// MCP49xx frame bit positions and the fixed configuration bits.
package spi2dac_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_CS_SETUP = 3'd1;
    localparam state_t S_SHIFT    = 3'd2;
    localparam state_t S_CS_HOLD  = 3'd3;
    localparam state_t S_LDAC     = 3'd4;

    localparam int FRAME_LEN = 16;
    localparam int CH_BIT    = 15;
    localparam int BUF_BIT   = 14;
    localparam int GA_BIT    = 13;
    localparam int SHDN_BIT  = 12;
    localparam int DATA_MSB  = 11;

    localparam logic CFG_BUF    = 1'b0;
    localparam logic CFG_GA_N   = 1'b1;
    localparam logic CFG_SHDN_N = 1'b1;

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic ch,
                                                         input logic [DATA_MSB:0] data);
        logic [FRAME_LEN-1:0] f;
        f              = '0;
        f[CH_BIT]      = ch;
        f[BUF_BIT]     = CFG_BUF;
        f[GA_BIT]      = CFG_GA_N;
        f[SHDN_BIT]    = CFG_SHDN_N;
        f[DATA_MSB:0]  = data;
        return f;
    endfunction

endpackage

// File: rtl/spi2dac_multi_sck_div.sv
// SCK half-period divider: emits a one-cycle half_tick every SCK_DIV cycles,
// held at zero while clear is high so each transfer starts on a fresh period.
module sck_div #(
    parameter int SCK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic half_tick
);

    localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        half_tick = !clear && (cnt_q == CW'(SCK_DIV - 1));
        cnt_d     = cnt_q + 1'b1;
        if (clear || half_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi2dac_multi.sv
// Multi-channel MCP49xx SPI DAC driver: one 16-bit frame per channel per load,
// then an LDAC pulse. Define SPI2DAC_MULTI_OVERRUN_EN to build the sticky overrun flag.
module spi2dac_multi
    import spi2dac_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int NCH     = 2,
    parameter int SCK_DIV = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  load,
    input  logic [NCH*DATA_W-1:0] data_in,
    output logic                  busy,
    output logic                  overrun,
    output logic                  DAC_SDI,
    output logic                  DAC_CS,
    output logic                  DAC_SCK,
    output logic                  DAC_LD
);

    localparam logic LAST_CH = 1'(NCH - 1);

    state_t                state_q, state_d;
    logic [NCH*DATA_W-1:0] hold_q, hold_d;
    logic                  ch_q, ch_d;
    logic [FRAME_LEN-1:0]  shift_q, shift_d;
    logic [3:0]            bit_q, bit_d;
    logic                  ld_cnt_q, ld_cnt_d;
    logic                  sdi_q, sdi_d;
    logic                  cs_q, cs_d;
    logic                  sck_q, sck_d;
    logic                  ld_q, ld_d;

    logic                  half_tick;
    logic [NCH*DATA_W-1:0] src;
    logic                  ch_sel;
    logic [DATA_W-1:0]     sample;
    logic [DATA_MSB:0]     data12;
    logic [FRAME_LEN-1:0]  next_frame;

    sck_div #(.SCK_DIV(SCK_DIV)) u_sck_div (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .clear     (state_q == S_IDLE),
        .half_tick (half_tick)
    );

    // Next frame: channel 0 straight from data_in at capture, later channels from the holding register.
    always_comb begin
        src        = (state_q == S_IDLE) ? data_in : hold_q;
        ch_sel     = (state_q == S_IDLE) ? 1'b0 : ch_q + 1'b1;
        sample     = src[((NCH > 1) ? int'(ch_sel) : 0) * DATA_W +: DATA_W];
        data12     = 12'(sample) << (12 - DATA_W);
        next_frame = build_frame(ch_sel, data12);
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ch_d     = ch_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        ld_cnt_d = ld_cnt_q;
        sdi_d    = sdi_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        ld_d     = ld_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    hold_d  = data_in;
                    ch_d    = 1'b0;
                    sdi_d   = next_frame[FRAME_LEN-1];
                    shift_d = {next_frame[FRAME_LEN-2:0], 1'b0};
                    cs_d    = 1'b0;
                    state_d = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                if (half_tick) begin
                    sck_d   = 1'b1;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            // Falling SCK shifts out the next bit; a low phase after the counter wraps ends the frame.
            S_SHIFT: begin
                if (half_tick) begin
                    if (sck_q) begin
                        sck_d   = 1'b0;
                        bit_d   = bit_q + 4'd1;
                        sdi_d   = shift_q[FRAME_LEN-1];
                        shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
                    end else if (bit_q == 4'd0) begin
                        cs_d    = 1'b1;
                        state_d = S_CS_HOLD;
                    end else begin
                        sck_d = 1'b1;
                    end
                end
            end
            S_CS_HOLD: begin
                if (half_tick) begin
                    if (ch_q != LAST_CH) begin
                        ch_d    = ch_sel;
                        sdi_d   = next_frame[FRAME_LEN-1];
                        shift_d = {next_frame[FRAME_LEN-2:0], 1'b0};
                        cs_d    = 1'b0;
                        state_d = S_CS_SETUP;
                    end else begin
                        ld_d     = 1'b0;
                        ld_cnt_d = 1'b0;
                        state_d  = S_LDAC;
                    end
                end
            end
            S_LDAC: begin
                if (half_tick) begin
                    if (ld_cnt_q) begin
                        ld_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ld_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            ch_q     <= 1'b0;
            shift_q  <= '0;
            bit_q    <= '0;
            ld_cnt_q <= 1'b0;
            sdi_q    <= 1'b0;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            ld_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            ch_q     <= ch_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            ld_cnt_q <= ld_cnt_d;
            sdi_q    <= sdi_d;
            cs_q     <= cs_d;
            sck_q    <= sck_d;
            ld_q     <= ld_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign DAC_SDI = sdi_q;
    assign DAC_CS  = cs_q;
    assign DAC_SCK = sck_q;
    assign DAC_LD  = ld_q;

`ifdef SPI2DAC_MULTI_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q | (load & busy);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi2dac_multi.sv
// Randomised bench for spi2dac_multi: a transaction-level model predicts busy,
// overrun and the frames; a pin monitor reassembles frames from SCK/SDI.
module tb_spi2dac_multi;

    localparam int DW    = 10;
    localparam int NC    = 2;
    localparam int HP    = 2;
    localparam int TOTAL = NC * 34 * HP + 2 * HP;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N  = 1'b0;
    logic          load     = 1'b0;
    logic [NC*DW-1:0] data_in = '0;
    logic          busy, overrun, DAC_SDI, DAC_CS, DAC_SCK, DAC_LD;

    logic          load1  = 1'b0;
    logic [11:0]   data1  = '0;
    logic          busy1, overrun1, sdi1, cs1, sck1, ld1;

    int            checks = 0;
    int            errors = 0;

    int            model_left = 0;
    logic          model_ovr  = 1'b0;
    logic [15:0]   exp_q[$];

    logic [15:0]   rx_bits = '0;
    int            rx_n    = 0;
    time           t_busy, t_ld;

    logic [15:0]   rx1_bits = '0;
    int            rx1_n    = 0;
    int            frames1  = 0;
    time           t_busy1, t_ld1;

    always #10 CLOCK_50 = ~CLOCK_50;

    spi2dac_multi #(.DATA_W(DW), .NCH(NC), .SCK_DIV(HP)) u_dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .load     (load),
        .data_in  (data_in),
        .busy     (busy),
        .overrun  (overrun),
        .DAC_SDI  (DAC_SDI),
        .DAC_CS   (DAC_CS),
        .DAC_SCK  (DAC_SCK),
        .DAC_LD   (DAC_LD)
    );

    spi2dac_multi #(.DATA_W(12), .NCH(1), .SCK_DIV(1)) u_dut1 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .load     (load1),
        .data_in  (data1),
        .busy     (busy1),
        .overrun  (overrun1),
        .DAC_SDI  (sdi1),
        .DAC_CS   (cs1),
        .DAC_SCK  (sck1),
        .DAC_LD   (ld1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] refFrame(input int ch, input int sample, input int dw);
        return 16'((ch << 15) | (1 << 13) | (1 << 12) | (sample << (12 - dw)));
    endfunction

    // Transaction model: a captured strobe keeps the driver busy for TOTAL cycles.
    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            model_left = 0;
            model_ovr  = 1'b0;
            exp_q.delete();
        end else if (model_left > 0) begin
`ifdef SPI2DAC_MULTI_OVERRUN_EN
            if (load) model_ovr = 1'b1;
`endif
            model_left--;
        end else if (load) begin
            model_left = TOTAL;
            for (int c = 0; c < NC; c++) begin
                exp_q.push_back(refFrame(c, int'((data_in >> (c * DW)) & ((1 << DW) - 1)), DW));
            end
        end
    end

    always @(negedge CLOCK_50) begin
        checkOutput("busy", {31'd0, busy}, {31'd0, model_left > 0});
        checkOutput("overrun", {31'd0, overrun}, {31'd0, model_ovr});
    end

    // Pin-level frame capture: the DAC samples SDI on rising SCK while CS is low.
    always @(negedge DAC_CS) rx_n = 0;
    always @(posedge DAC_SCK) begin
        if (!DAC_CS) begin
            rx_bits = {rx_bits[14:0], DAC_SDI};
            rx_n++;
        end
    end
    always @(posedge DAC_CS) begin
        if (RESET_N) begin
            checkOutput("sck_rises", rx_n, 16);
            if (exp_q.size() == 0) checkOutput("frame_unexpected", {16'd0, rx_bits}, 32'hFFFF_FFFF);
            else checkOutput("frame", {16'd0, rx_bits}, {16'd0, exp_q.pop_front()});
        end
        rx_n = 0;
    end

    always @(posedge busy) t_busy = $time;
    always @(negedge busy) if (RESET_N) checkOutput("busy_width", ($time - t_busy) / 20, TOTAL);
    always @(negedge DAC_LD) t_ld = $time;
    always @(posedge DAC_LD) if (RESET_N) checkOutput("ld_width", ($time - t_ld) / 20, 2 * HP);

    always @(negedge cs1) rx1_n = 0;
    always @(posedge sck1) begin
        if (!cs1) begin
            rx1_bits = {rx1_bits[14:0], sdi1};
            rx1_n++;
        end
    end
    always @(posedge cs1) begin
        if (RESET_N) begin
            frames1++;
            checkOutput("dut1_sck_rises", rx1_n, 16);
            checkOutput("dut1_frame", {16'd0, rx1_bits}, 32'h3ABC);
        end
    end
    always @(posedge busy1) t_busy1 = $time;
    always @(negedge busy1) if (RESET_N) checkOutput("dut1_busy_width", ($time - t_busy1) / 20, 36);
    always @(negedge ld1) t_ld1 = $time;
    always @(posedge ld1) if (RESET_N) checkOutput("dut1_ld_width", ($time - t_ld1) / 20, 2);

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic applyStimulus(input logic [NC*DW-1:0] d);
        data_in = d;
        load    = 1'b1;
        @(negedge CLOCK_50);
        load    = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 1000 && model_left > 0; i++) @(negedge CLOCK_50);
        checkOutput("idle_reached", {31'd0, model_left > 0}, 32'd0);
        waitCycles(4);
    endtask

    initial begin
        // Reset with a strobe inside it, then a quiet idle stretch.
        @(negedge CLOCK_50);
        data_in = 20'hABCDE;
        load    = 1'b1;
        waitCycles(2);
        load    = 1'b0;
        RESET_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            checkOutput("idle_pins", {26'd0, DAC_CS, DAC_SCK, DAC_SDI, DAC_LD, busy, overrun},
                        {26'd0, 6'b100100});
        end

        $display("[TB] directed two-channel transfer");
        applyStimulus({10'h3FF, 10'h155});
        checkOutput("cs_low_at_capture", {31'd0, DAC_CS}, 32'd0);
        waitIdle();

        $display("[TB] second strobe mid-transfer");
        applyStimulus({10'h0F0, 10'h00F});
        waitCycles(49);
        applyStimulus({10'h111, 10'h222});
        waitIdle();

        $display("[TB] strobe on the busy-fall edge, then one cycle later");
        applyStimulus({10'h2AA, 10'h133});
        for (int i = 0; i < 1000 && model_left != 1; i++) @(negedge CLOCK_50);
        data_in = {10'h001, 10'h002};
        load    = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("busy_fell", {31'd0, busy}, 32'd0);
        data_in = {10'h3C3, 10'h05A};
        @(negedge CLOCK_50);
        load    = 1'b0;
        checkOutput("restart_busy", {31'd0, busy}, 32'd1);
        waitIdle();

        $display("[TB] reset during channel 0 shift");
        applyStimulus({10'h155, 10'h2AA});
        waitCycles(20);
        checkOutput("pre_reset_cs", {31'd0, DAC_CS}, 32'd0);
        RESET_N = 1'b0;
        #1;
        checkOutput("async_reset_pins", {29'd0, DAC_CS, DAC_SCK, DAC_LD}, {29'd0, 3'b101});
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        waitCycles(3);
        applyStimulus({10'h123, 10'h321});
        waitIdle();

        $display("[TB] randomised strobes and data");
        for (int it = 0; it < 12; it++) begin
            applyStimulus(NC*DW'($urandom));
            for (int k = 0; k < int'($urandom_range(120, 220)); k++) begin
                data_in = NC*DW'($urandom);
                load    = ($urandom_range(0, 30) == 0);
                @(negedge CLOCK_50);
            end
            load = 1'b0;
            waitIdle();
        end
        checkOutput("frames_outstanding", exp_q.size(), 0);

        $display("[TB] single-channel 12-bit build");
        data1 = 12'hABC;
        load1 = 1'b1;
        @(negedge CLOCK_50);
        load1 = 1'b0;
        data1 = 12'h000;
        for (int i = 0; i < 100 && busy1; i++) @(negedge CLOCK_50);
        waitCycles(4);
        checkOutput("dut1_frames", frames1, 1);
        checkOutput("dut1_overrun", {31'd0, overrun1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
